// File: rtl/imem_prefetch.sv
// Instruction prefetch queue: fetches ahead of decode, absorbs stalls and flushes on redirect.
// Optional IMEM_PREFETCH_BYPASS_EN presents a response to decode the same cycle it arrives.
module imem_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc4,
  input  logic        hold,
  input  logic        redirect,
  input  logic [31:0] redirect_addr
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   fpc_q, fpc_d, rpc_q, rpc_d;
  logic [CW-1:0] count_q, count_d, outst_q, outst_d, drop_q, drop_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   pc4_mem_q  [DEPTH];

  logic [CW:0] used;
  logic        grant, resp_live, q_empty, push, pop, byp_show, byp_take;
  logic        unused_addr_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Request handshake: mem_req/mem_addr are held until mem_gnt (transfer on
  // mem_req && mem_gnt) or until a redirect withdraws the request.
  // outst_q counts every in-flight fetch, stale or not; drop_q is the stale subset.
  assign used      = {1'b0, count_q} + {1'b0, outst_q};
  assign mem_req   = !rst && !redirect && (used < (CW+1)'(DEPTH));
  assign mem_addr  = fpc_q;
  assign grant     = mem_req && mem_gnt;
  assign resp_live = mem_rvalid && !redirect && (drop_q == '0);
  assign q_empty   = (count_q == '0);

`ifdef IMEM_PREFETCH_BYPASS_EN
  assign byp_show = !rst && resp_live && q_empty;
`else
  assign byp_show = 1'b0;
`endif
  assign byp_take = byp_show && !hold;

  assign push = resp_live && !byp_take;
  assign pop  = !rst && !q_empty && !hold && !redirect;

  assign unused_addr_bits = ^redirect_addr[1:0];

  always_comb begin
    inst_valid = 1'b0;
    inst       = 32'd0;
    pc4        = 32'd0;
    if (!rst && !q_empty) begin
      inst_valid = 1'b1;
      inst       = inst_mem_q[rd_q];
      pc4        = pc4_mem_q[rd_q];
    end else if (byp_show) begin
      inst_valid = 1'b1;
      inst       = mem_rdata;
      pc4        = rpc_q + 32'd4;
    end
  end

  always_comb begin
    fpc_d   = fpc_q;
    rpc_d   = rpc_q;
    count_d = count_q;
    outst_d = outst_q;
    drop_d  = drop_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (redirect) begin
      // Everything still in flight becomes stale, including earlier stale fetches.
      fpc_d   = {redirect_addr[31:2], 2'b00};
      rpc_d   = {redirect_addr[31:2], 2'b00};
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
      outst_d = outst_q - CW'(mem_rvalid);
      drop_d  = outst_q - CW'(mem_rvalid);
    end else begin
      if (grant) fpc_d = fpc_q + 32'd4;
      outst_d = outst_q + CW'(grant) - CW'(mem_rvalid);
      if (mem_rvalid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (resp_live) rpc_d = rpc_q + 32'd4;
      if (push) wr_d = ptr_inc(wr_q);
      if (pop) rd_d = ptr_inc(rd_q);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q   <= RESET_PC;
      rpc_q   <= RESET_PC;
      count_q <= '0;
      outst_q <= '0;
      drop_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      fpc_q   <= fpc_d;
      rpc_q   <= rpc_d;
      count_q <= count_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      inst_mem_q[wr_q] <= mem_rdata;
      pc4_mem_q[wr_q]  <= rpc_q + 32'd4;
    end
  end

endmodule
